// File: rtl/clk_switch_pkg.sv
// clk_switch_pkg: shared FSM state type for the clock switch controller
package clk_switch_pkg;
  typedef enum logic {IDLE, SETTLE} state_e;
endpackage

// File: rtl/clk_switch_timer.sv
// clk_switch_timer: loadable settle down-counter that holds at zero
// Ports: clk/rst (sync, active-high), load + load_val preset the count,
// en decrements once per cycle, zero_o flags a count of zero.
module clk_switch_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequences select changes for a glitch-free clock mux
// Ports: clk_i/rst_i (sync, active-high); req_valid_i/req_sel_i/req_ready_o
// request handshake; clk_active_i per-source alive flags; sel_o registered
// mux select; busy_o settling; done_o/err_o/fallback_o one-cycle pulses.
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int NUM_INPUTS    = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int DEFAULT_SEL   = 0,
  localparam int SEL_WIDTH    = $clog2(NUM_INPUTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [SEL_WIDTH-1:0]  req_sel_i,
  output logic                  req_ready_o,
  input  logic [NUM_INPUTS-1:0] clk_active_i,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  fallback_o
);
  localparam int NSEL = 1 << SEL_WIDTH;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SEL_WIDTH-1:0] DEF = SEL_WIDTH'(DEFAULT_SEL);
  state_e state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic done_q, done_d, err_q, err_d, fb_q, fb_d;
  logic [NSEL-1:0] act_ext;
  logic fb_pend, acc, bad, start, zero, settle_end;
  // widen so any select code can index; nonexistent sources read as dead
  assign act_ext = NSEL'(clk_active_i);
  always_comb begin
    fb_pend = state_q == IDLE && !act_ext[sel_q] && sel_q != DEF && act_ext[DEF];
    req_ready_o = state_q == IDLE && !fb_pend && !rst_i;
    acc = req_valid_i && req_ready_o;
    bad = int'(req_sel_i) >= NUM_INPUTS || !act_ext[req_sel_i];
    start = fb_pend || (acc && !bad && req_sel_i != sel_q);
    settle_end = state_q == SETTLE && zero;
    sel_d = fb_pend ? DEF : start ? req_sel_i : sel_q;
    state_d = start ? SETTLE : settle_end ? IDLE : state_q;
    done_d = settle_end || (acc && !bad && req_sel_i == sel_q);
    err_d = acc && bad;
    fb_d = fb_pend;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q <= DEF;
      done_q <= 1'b0;
      err_q <= 1'b0;
      fb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      done_q <= done_d;
      err_q <= err_d;
      fb_q <= fb_d;
    end
  end
  clk_switch_timer #(.W(CW)) u_timer (
    .clk(clk_i),
    .rst(rst_i),
    .load(start),
    .load_val(CW'(SETTLE_CYCLES - 1)),
    .en(state_q == SETTLE),
    .zero_o(zero)
  );
  assign sel_o = sel_q;
  assign busy_o = state_q == SETTLE;
  assign done_o = done_q;
  assign err_o = err_q;
  assign fallback_o = fb_q;
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: directed plus random checks against a cycle-level model
module tb_clk_switch_ctrl;
  localparam int S = 8;
  logic clk_i = 0;
  logic rst_i, req_valid_i, req_ready_o, busy_o, done_o, err_o, fallback_o;
  logic [1:0] req_sel_i, sel_o;
  logic [3:0] clk_active_i;
  logic v3, ready3, busy3, done3, err3, fb3;
  logic [1:0] s3, sel3;
  int errs = 0, checks = 0;
  int m_left;
  logic [1:0] m_sel;
  logic e_done, e_err, e_fb, e3;

  always #5 clk_i = ~clk_i;

  clk_switch_ctrl #(.NUM_INPUTS(4), .SETTLE_CYCLES(S), .DEFAULT_SEL(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_sel_i(req_sel_i),
    .req_ready_o(req_ready_o), .clk_active_i(clk_active_i), .sel_o(sel_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .fallback_o(fallback_o));

  clk_switch_ctrl #(.NUM_INPUTS(3), .SETTLE_CYCLES(S), .DEFAULT_SEL(0)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(v3), .req_sel_i(s3),
    .req_ready_o(ready3), .clk_active_i(3'b111), .sel_o(sel3),
    .busy_o(busy3), .done_o(done3), .err_o(err3), .fallback_o(fb3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, check ready, advance model, check registered outputs
  task automatic step(input logic r, input logic v, input logic [1:0] s, input logic [3:0] a);
    logic fbp;
    rst_i = r; req_valid_i = v; req_sel_i = s; clk_active_i = a;
    #1;
    fbp = m_left == 0 && !a[m_sel] && m_sel != 2'd0 && a[0];
    chk("ready", 32'(req_ready_o), 32'(!r && m_left == 0 && !fbp));
    e_done = 0; e_err = 0; e_fb = 0;
    e3 = !r && v3 && s3 == 2'd3;
    if (r) begin
      m_sel = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      e_done = m_left == 0;
    end else if (fbp) begin
      m_sel = 0; m_left = S; e_fb = 1;
    end else if (v) begin
      if (!a[s]) e_err = 1;
      else if (s == m_sel) e_done = 1;
      else begin m_sel = s; m_left = S; end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    chk("sel", 32'(sel_o), 32'(m_sel));
    chk("busy", 32'(busy_o), 32'(m_left > 0));
    chk("done", 32'(done_o), 32'(e_done));
    chk("err", 32'(err_o), 32'(e_err));
    chk("fallback", 32'(fallback_o), 32'(e_fb));
    chk("err3", 32'(err3), 32'(e3));
    chk("sel3", 32'(sel3), 32'd0);
  endtask

  task automatic idle(input int n, input logic [3:0] a);
    for (int i = 0; i < n; i++) step(0, 0, 0, a);
  endtask

  initial begin
    m_sel = 0; m_left = 0; v3 = 0; s3 = 0;
    rst_i = 1; req_valid_i = 0; req_sel_i = 0; clk_active_i = 4'hF;
    @(negedge clk_i);
    step(1, 0, 0, 4'hF);
    step(1, 1, 2, 4'hF);
    // switch to 2 with full settle
    step(0, 1, 2, 4'hF);
    idle(10, 4'hF);
    // same-source request completes immediately
    step(0, 1, 2, 4'hF);
    idle(2, 4'hF);
    step(0, 1, 0, 4'hF);
    idle(10, 4'hF);
    step(0, 1, 0, 4'hF);
    idle(1, 4'hF);
    // dead target rejected
    step(0, 1, 2, 4'b1011);
    idle(1, 4'b1011);
    // out-of-range select on the 3-input instance
    v3 = 1; s3 = 3;
    step(0, 0, 0, 4'hF);
    v3 = 0; s3 = 0;
    idle(1, 4'hF);
    // fallback from 3 beats a concurrent request
    step(0, 1, 3, 4'hF);
    idle(10, 4'hF);
    step(0, 1, 1, 4'b0111);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 4'b0111);
    // reset in the middle of settling
    step(0, 1, 2, 4'hF);
    idle(3, 4'hF);
    step(1, 0, 0, 4'hF);
    idle(3, 4'hF);
    // current and default both dead: no fallback, requests still taken
    step(0, 1, 2, 4'hF);
    idle(10, 4'hF);
    idle(2, 4'b1010);
    step(0, 1, 1, 4'b1010);
    idle(10, 4'b1010);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] a;
      a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      step($urandom_range(0, 40) == 0, 1'($urandom), 2'($urandom), a);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
